btn_fifo_push: RTL
==================

Name: btn_fifo_push

Overview:
- Sits directly downstream of the button debouncer and consumes its debounced level output.
- Turns each debounced press into a single-cycle FIFO write strobe carrying the switch data captured at that moment.
- Optional auto-repeat: holding the button produces further writes at a fixed rate.
- Writes attempted while the FIFO reports full are dropped and counted.

Parameters:
- DATA_W, 8, width of switch data and of FIFO write data.
- CNT_W, 25, width of the hold/repeat timer; must hold HOLD_CYC-1 and RPT_CYC-1.
- HOLD_CYC, 19000000, cycles from first write to first repeat (0.5 s at 38 MHz); legal range 2..2^CNT_W.
- RPT_CYC, 3800000, cycles between successive repeats (100 ms at 38 MHz); legal range 2..2^CNT_W.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 gives exactly one write per press.
- DROP_W, 8, width of the dropped-write counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- n_reset  in  1  synchronous reset, active-high (despite the name).
- db_in  in  1  debounced button level from the debouncer.
- data_in  in  DATA_W  switch value; sampled only at fire events.
- fifo_full  in  1  FIFO full flag.
- wr_en  out  1  FIFO write strobe, one cycle per accepted fire.
- wr_data  out  DATA_W  data presented with wr_en.
- drop_cnt  out  DROP_W  saturating count of fires blocked by fifo_full.
- held  out  1  high while FSM is in HOLD or REPEAT.

Behaviour:
- Synchronous reset, active-high; every register updates only on posedge clk.
- Reset values:
  - state=IDLE, cnt=0, prev=1, wr_en=0, wr_data=0, drop_cnt=0.
  - held is decoded from state, so it is 0.
- prev <= db_in every cycle, including reset release.
  - rise = db_in & ~prev.
  - A button already held when reset deasserts does not fire; a real 0->1 transition is required.
- Fire event (edge at which the FSM fires):
  - If fifo_full=0: wr_en<=1 and wr_data<=data_in. wr_en is high for exactly the cycle after that edge.
  - If fifo_full=1: wr_en<=0, wr_data holds its value, and drop_cnt increments, saturating at all-ones.
  - On every non-fire edge: wr_en<=0 and wr_data holds.
- FSM transitions:
  - IDLE: on rise -> fire, cnt<=0, go to HOLD. Otherwise stay.
  - HOLD: if db_in=0 -> IDLE, cnt<=0, no fire. Else if cnt==HOLD_CYC-1: when REPEAT_EN=1, fire, cnt<=0, go to REPEAT; when REPEAT_EN=0, stay in HOLD with cnt frozen. Else cnt<=cnt+1.
  - REPEAT: if db_in=0 -> IDLE, cnt<=0. Else if cnt==RPT_CYC-1 -> fire, cnt<=0. Else cnt<=cnt+1.
- Timing:
  - Latency from db_in rise sampled at edge E0 to wr_en high is one cycle (registered at E0).
  - The first repeat fires at edge E0+HOLD_CYC.
  - Later repeats fire every RPT_CYC edges.
- Release has priority over timer expiry: db_in=0 on the expiry edge gives no fire.
- A rise is only acted on in IDLE; db_in is held level, so no rise can occur in HOLD/REPEAT.
- fifo_full is sampled only on fire edges.
  - A dropped fire is not retried.
  - The timer continues normally after a drop.
- Reset mid-hold:
  - wr_en clears at the next edge and state returns to IDLE.
  - No fire occurs until db_in goes low and then high again.
- drop_cnt clears only on reset and never wraps.

Test Plan (bench uses HOLD_CYC=8, RPT_CYC=4, REPEAT_EN=1, DROP_W=2):
- Reset with db_in=1, then release reset and hold db_in=1 for 20 cycles -> wr_en never asserts; held=0.
- db_in 0->1 for 5 cycles, data_in=0xA5, fifo_full=0 -> one wr_en pulse, 1 cycle after the rise is sampled, with wr_data=0xA5; no further pulses.
- db_in held high 30 cycles, data_in incrementing each cycle -> wr_en at offsets 1, 9, 13, 17, 21, 25, 29; each wr_data equals data_in on the preceding edge.
- fifo_full=1, five separate presses -> wr_en never asserts; drop_cnt reads 1, 2, 3, 3, 3 (saturates).
- Release on the exact edge where cnt==HOLD_CYC-1 -> no second pulse, FSM in IDLE; next press fires normally.
- Assert n_reset while in REPEAT with db_in still 1 -> wr_en=0 and drop_cnt=0 next cycle; no fire until db_in goes 0 then 1.
- Rebuild with REPEAT_EN=0, hold db_in 30 cycles -> exactly one wr_en pulse.

Source files
------------

// File: rtl/btn_fifo_push.sv
// Converts debounced button presses into single-cycle FIFO write strobes that carry the
// switch data, with optional hold-to-repeat and a saturating count of writes lost to a full FIFO.
module btn_fifo_push #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 25,
  parameter int HOLD_CYC  = 19000000,
  parameter int RPT_CYC   = 3800000,
  parameter int REPEAT_EN = 1,
  parameter int DROP_W    = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              db_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              held
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prev_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DROP_W-1:0] drop_q;
  logic              rise;
  logic              fire;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  assign rise = db_in & ~prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          fire    = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Release wins over timer expiry on the same edge.
        if (!db_in) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          if (REPEAT_EN != 0) begin
            fire    = 1'b1;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REPEAT: begin
        if (!db_in) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == RPT_LAST) begin
          fire  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // prev resets high so a button already held at reset release does not fire.
  always_ff @(posedge clk) begin
    prev_q <= n_reset ? 1'b1 : db_in;
    if (n_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_en_q <= fire & ~fifo_full;
      if (fire) begin
        if (fifo_full) drop_q <= sat_inc(drop_q);
        else           wr_data_q <= data_in;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign drop_cnt = drop_q;
  assign held     = (state_q == S_HOLD) || (state_q == S_REPEAT);

endmodule
